// File: rtl/wdt.sv
// wdt: watchdog timer rib slave that raises a warn interrupt, then a reset-request pulse.
// Define WDT_LOCK_EN to implement CTRL.LOCK (freezes CTRL/LOAD until rst).
module wdt #(
  parameter int unsigned DIV       = 1,
  parameter int unsigned RST_PULSE = 16,
  parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        int_sig_o,
  output logic        rst_req_o
);

  typedef enum logic [1:0] {IDLE, RUN, WARN, BITE} state_e;

  localparam logic [7:0]  A_CTRL   = 8'h00;
  localparam logic [7:0]  A_LOAD   = 8'h04;
  localparam logic [7:0]  A_COUNT  = 8'h08;
  localparam logic [7:0]  A_KICK   = 8'h0C;
  localparam logic [7:0]  A_STATUS = 8'h10;
  localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
  localparam logic [7:0]  PULSE_M1 = 8'(RST_PULSE - 1);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic        int_en_q, int_en_d;
  logic        rst_en_q, rst_en_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  pulse_q, pulse_d;
  logic        warn_pend_q, warn_pend_d;
  logic        bitten_q, bitten_d;
  logic        rst_req_q, rst_req_d;

  logic        locked;
  logic        wr_ctrl, wr_load, wr_kick, wr_status;
  logic        ctrl_ok, load_ok, kick, tick;
  logic        unused_addr;

  assign unused_addr = ^addr_i[31:8];

  assign wr_ctrl   = we_i && (addr_i[7:0] == A_CTRL);
  assign wr_load   = we_i && (addr_i[7:0] == A_LOAD);
  assign wr_kick   = we_i && (addr_i[7:0] == A_KICK);
  assign wr_status = we_i && (addr_i[7:0] == A_STATUS);
  // CTRL is frozen while biting so software cannot abort the reset pulse.
  assign ctrl_ok   = wr_ctrl && !locked && (state_q != BITE);
  assign load_ok   = wr_load && !locked;
  assign kick      = wr_kick && (data_i == KICK_KEY);
  assign tick      = (presc_q == DIV_M1);

`ifdef WDT_LOCK_EN
  logic lock_q, lock_d;

  assign locked = lock_q;

  always_comb begin
    lock_d = lock_q | (ctrl_ok & data_i[3]);
  end

  always_ff @(posedge clk) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    int_en_d    = int_en_q;
    rst_en_d    = rst_en_q;
    load_d      = load_q;
    count_d     = count_q;
    presc_d     = presc_q;
    pulse_d     = pulse_q;
    warn_pend_d = warn_pend_q;
    bitten_d    = bitten_q;

    if (load_ok) load_d = data_i;
    if (ctrl_ok) begin
      en_d     = data_i[0];
      int_en_d = data_i[1];
      rst_en_d = data_i[2];
    end
    // W1C first so that a same-cycle hardware set below overrides it.
    if (wr_status) begin
      warn_pend_d = warn_pend_q & ~data_i[0];
      bitten_d    = bitten_q & ~data_i[1];
    end

    unique case (state_q)
      IDLE: begin
        if (ctrl_ok && data_i[0]) begin
          state_d = RUN;
          count_d = load_q;
          presc_d = '0;
        end
      end
      RUN, WARN: begin
        if (ctrl_ok && !data_i[0]) begin
          state_d = IDLE;
        end else if (kick) begin
          state_d = RUN;
          count_d = load_q;
          presc_d = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + 16'd1;
          if (tick) begin
            if (count_q != '0) begin
              count_d = count_q - 32'd1;
            end else if (state_q == RUN) begin
              state_d     = WARN;
              count_d     = load_q;
              warn_pend_d = 1'b1;
            end else if (rst_en_q) begin
              state_d  = BITE;
              pulse_d  = '0;
              bitten_d = 1'b1;
            end else begin
              count_d     = load_q;
              warn_pend_d = 1'b1;
            end
          end
        end
      end
      BITE: begin
        if (pulse_q == PULSE_M1) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else begin
          pulse_d = pulse_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    rst_req_d = (state_d == BITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      int_en_q    <= 1'b0;
      rst_en_q    <= 1'b0;
      load_q      <= '0;
      count_q     <= '0;
      presc_q     <= '0;
      pulse_q     <= '0;
      warn_pend_q <= 1'b0;
      bitten_q    <= 1'b0;
      rst_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      int_en_q    <= int_en_d;
      rst_en_q    <= rst_en_d;
      load_q      <= load_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      pulse_q     <= pulse_d;
      warn_pend_q <= warn_pend_d;
      bitten_q    <= bitten_d;
      rst_req_q   <= rst_req_d;
    end
  end

  always_comb begin
    data_o = '0;
    unique case (addr_i[7:0])
      A_CTRL:   data_o = {28'd0, locked, rst_en_q, int_en_q, en_q};
      A_LOAD:   data_o = load_q;
      A_COUNT:  data_o = count_q;
      A_STATUS: data_o = {30'd0, bitten_q, warn_pend_q};
      default:  data_o = '0;
    endcase
  end

  assign int_sig_o = warn_pend_q & int_en_q;
  assign rst_req_o = rst_req_q;

endmodule
